apb_master: RTL and testbench
=============================

# apb_master

Single-outstanding APB initiator that turns a valid/ready command stream into APB3 transfers and returns each completion on a valid/ready response stream. It is the initiator end of the APB fabric: its `p*_o` outputs drive the APB demux input bus, and its `p*_i` inputs take the demux's muxed return. An optional watchdog aborts transfers whose slave never asserts PREADY.

## Interface
- `APB_ADDR_WIDTH`, default 32: address width.
- `APB_DATA_WIDTH`, default 32: data width.
- `TIMEOUT_CYCLES`, default 16: maximum ACCESS-phase cycles before abort. Must be at least 1. Used only with `APB_MASTER_TIMEOUT_EN`.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `cmd_valid_i`  in  1  command present.
- `cmd_ready_o`  out  1  command accepted when high together with `cmd_valid_i`.
- `cmd_addr_i`  in  APB_ADDR_WIDTH  transfer address.
- `cmd_write_i`  in  1  1 = write, 0 = read.
- `cmd_wdata_i`  in  APB_DATA_WIDTH  write data.
- `rsp_valid_o`  out  1  response present.
- `rsp_ready_i`  in  1  response consumed.
- `rsp_rdata_o`  out  APB_DATA_WIDTH  read data; 0 for writes and aborts.
- `rsp_err_o`  out  1  PSLVERR, or timeout abort.
- `psel_o`, `penable_o`, `pwrite_o`  out  1 each  APB control.
- `paddr_o`  out  APB_ADDR_WIDTH  APB address.
- `pwdata_o`  out  APB_DATA_WIDTH  APB write data.
- `prdata_i`  in  APB_DATA_WIDTH  APB read data.
- `pready_i`, `pslverr_i`  in  1 each  APB completion and error.

## Operation
- FSM states are IDLE, SETUP, ACCESS and RESP. Every output is a register or a decode of the state register. No output has a combinational path from any input.
- IDLE:
  - `cmd_ready_o` = 1.
  - On `cmd_valid_i`, latch addr, write and wdata into `paddr_o`, `pwrite_o` and `pwdata_o`, then go to SETUP.
- SETUP: `psel_o` = 1, `penable_o` = 0. Unconditionally go to ACCESS.
- ACCESS:
  - `psel_o` = 1, `penable_o` = 1.
  - If `pready_i` is high, capture `rsp_err_o` <= `pslverr_i` and `rsp_rdata_o` <= (`pwrite_o` ? 0 : `prdata_i`), then go to RESP.
  - Otherwise stay in ACCESS.
- RESP:
  - `rsp_valid_o` = 1, `psel_o` = 0, `penable_o` = 0.
  - When `rsp_ready_i` is high, go to IDLE.
- `paddr_o`, `pwrite_o` and `pwdata_o` are stable from SETUP through the final ACCESS cycle. They hold their last values in RESP and IDLE.
- `rsp_rdata_o` and `rsp_err_o` are stable while `rsp_valid_o` is high.
- `cmd_ready_o` is 0 in all states other than IDLE. A command that is not accepted is not sampled.

## Timing
- Reset value of every output is 0. The FSM resets to IDLE, so `cmd_ready_o` rises with the first clock after reset deassertion, by state decode.
- Reset mid-transfer: outputs drop to 0 asynchronously and the FSM returns to IDLE. The in-flight transfer is abandoned and no response is produced.
- Zero-wait-state latency, with the accept edge as cycle 0:
  - SETUP in cycle 1.
  - ACCESS in cycle 2, with `pready_i` = 1 sampled.
  - `rsp_valid_o` high in cycle 3.
- Each wait state adds one ACCESS cycle.
- Best-case throughput is one transfer per 4 cycles: IDLE, SETUP, ACCESS, RESP.
- `rsp_ready_i` held high makes RESP last exactly one cycle.

## Configuration
- Macro `APB_MASTER_TIMEOUT_EN`, defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS and increments in each ACCESS cycle with `pready_i` low.
  - If `pready_i` is low in the TIMEOUT_CYCLES-th ACCESS cycle, go to RESP with `rsp_err_o` = 1 and `rsp_rdata_o` = 0. `psel_o` and `penable_o` drop on that edge.
  - `pready_i` high in that same cycle is a normal completion; completion wins over timeout.
  - ACCESS never exceeds TIMEOUT_CYCLES cycles.
- Macro not defined: no counter exists, and ACCESS waits indefinitely for `pready_i`.

## Test plan
- Zero-wait write:
  - Stimulus: cmd addr=0x1000_0004, wdata=0xDEAD_BEEF, `pready_i` tied 1.
  - Response: SETUP in cycle 1 (psel=1, penable=0), ACCESS in cycle 2 (psel=1, penable=1), then `rsp_valid_o` in cycle 3 with rdata=0, err=0.
- Read with 3 wait states:
  - Stimulus: addr=0x2000_0010, `prdata_i`=0x1234_5678, `pready_i` high in the 4th ACCESS cycle.
  - Response: ACCESS lasts 4 cycles with paddr stable, then response rdata=0x1234_5678, err=0.
- Slave error:
  - Stimulus: read completing with `pslverr_i`=1, `prdata_i`=0xFFFF_FFFF.
  - Response: rsp_err=1, rdata=0xFFFF_FFFF.
- Response backpressure and back-to-back commands:
  - Stimulus: `rsp_ready_i`=0 for 5 cycles, `cmd_valid_i` held with the next command.
  - Response: rsp fields stable and `cmd_ready_o`=0 throughout. The second command is accepted only after the RESP handshake, with its SETUP 2 cycles after that handshake.
- Timeout, macro defined, TIMEOUT_CYCLES=4:
  - Stimulus A: `pready_i` stuck 0.
  - Response A: exactly 4 ACCESS cycles, then rsp err=1, rdata=0.
  - Stimulus B: `pready_i`=1 in the 4th ACCESS cycle.
  - Response B: normal completion with err=`pslverr_i`.
- Async reset asserted in the 2nd ACCESS cycle of a read:
  - Response: all outputs 0 immediately, no response ever issued, and a new command is accepted after reset release.

Source files
------------

// File: rtl/apb_master.sv
// Single-outstanding APB3 initiator: valid/ready command in, valid/ready response out.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS phases that exceed TIMEOUT_CYCLES.
module apb_master #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic                      cmd_write_i,
    input  logic [APB_DATA_WIDTH-1:0] cmd_wdata_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      psel_o,
    output logic                      penable_o,
    output logic                      pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [APB_DATA_WIDTH-1:0] pwdata_o,
    input  logic [APB_DATA_WIDTH-1:0] prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                    state_q;
    state_t                    state_n;
    logic [APB_ADDR_WIDTH-1:0] paddr_n;
    logic                      pwrite_n;
    logic [APB_DATA_WIDTH-1:0] pwdata_n;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata_n;
    logic                      rsp_err_n;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_n;
    logic             timeout_c;

    // High during the last ACCESS cycle the slave is allowed
    assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // Next-state and next register values
    always_comb begin
        state_n     = state_q;
        paddr_n     = paddr_o;
        pwrite_n    = pwrite_o;
        pwdata_n    = pwdata_o;
        rsp_rdata_n = rsp_rdata_o;
        rsp_err_n   = rsp_err_o;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_n       = cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                // cmd_ready_o stays low for the first cycle after reset release
                if (cmd_ready_o && cmd_valid_i) begin
                    paddr_n  = cmd_addr_i;
                    pwrite_n = cmd_write_i;
                    pwdata_n = cmd_wdata_i;
                    state_n  = ST_SETUP;
                end
            end
            ST_SETUP: begin
`ifdef APB_MASTER_TIMEOUT_EN
                cnt_n   = '0;
`endif
                state_n = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready_i) begin
                    rsp_err_n   = pslverr_i;
                    rsp_rdata_n = pwrite_o ? '0 : prdata_i;
                    state_n     = ST_RESP;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (timeout_c) begin
                    rsp_err_n   = 1'b1;
                    rsp_rdata_n = '0;
                    state_n     = ST_RESP;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State register; control outputs are registered decodes of the next state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cmd_ready_o <= 1'b0;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            rsp_valid_o <= 1'b0;
            paddr_o     <= '0;
            pwrite_o    <= 1'b0;
            pwdata_o    <= '0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            state_q     <= state_n;
            cmd_ready_o <= (state_n == ST_IDLE);
            psel_o      <= (state_n == ST_SETUP) || (state_n == ST_ACCESS);
            penable_o   <= (state_n == ST_ACCESS);
            rsp_valid_o <= (state_n == ST_RESP);
            paddr_o     <= paddr_n;
            pwrite_o    <= pwrite_n;
            pwdata_o    <= pwdata_n;
            rsp_rdata_o <= rsp_rdata_n;
            rsp_err_o   <= rsp_err_n;
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    // Wait-state counter for the watchdog
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_n;
        end
    end
`endif

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master; a bus-level monitor checks every cycle against expected transfers.
module tb_apb_master;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic [AW-1:0] cmd_addr_i = '0;
    logic          cmd_write_i = 1'b0;
    logic [DW-1:0] cmd_wdata_i = '0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [DW-1:0] rsp_rdata_o;
    logic          rsp_err_o;
    logic          psel_o;
    logic          penable_o;
    logic          pwrite_o;
    logic [AW-1:0] paddr_o;
    logic [DW-1:0] pwdata_o;
    logic [DW-1:0] prdata_i = '0;
    logic          pready_i = 1'b0;
    logic          pslverr_i = 1'b0;

    int checks = 0;
    int errors = 0;

    // Expected transfer currently on the bus and its expected response
    logic [AW-1:0] exp_addr = '0;
    logic          exp_write = 1'b0;
    logic [DW-1:0] exp_wdata = '0;
    logic [DW-1:0] exp_rdata = '0;
    logic          exp_err = 1'b0;
    logic          mon_en = 1'b0;

    apb_master #(
        .APB_ADDR_WIDTH(AW),
        .APB_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_addr_i (cmd_addr_i),
        .cmd_write_i(cmd_write_i),
        .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o  (rsp_err_o),
        .psel_o     (psel_o),
        .penable_o  (penable_o),
        .pwrite_o   (pwrite_o),
        .paddr_o    (paddr_o),
        .pwdata_o   (pwdata_o),
        .prdata_i   (prdata_i),
        .pready_i   (pready_i),
        .pslverr_i  (pslverr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus-level monitor: protocol exclusivity plus field values against the expected transfer
    always @(negedge clk_i) begin
        if (mon_en && !rst_i) begin
            chk("mon_ready_excl", 64'(cmd_ready_o && (psel_o || rsp_valid_o)), 64'd0);
            chk("mon_penable_needs_psel", 64'(penable_o && !psel_o), 64'd0);
            if (psel_o) begin
                chk("mon_paddr", 64'(paddr_o), 64'(exp_addr));
                chk("mon_pwrite", 64'(pwrite_o), 64'(exp_write));
                chk("mon_pwdata", 64'(pwdata_o), 64'(exp_wdata));
            end
            if (rsp_valid_o) begin
                chk("mon_rsp_rdata", 64'(rsp_rdata_o), 64'(exp_rdata));
                chk("mon_rsp_err", 64'(rsp_err_o), 64'(exp_err));
            end
        end
    end

    // One transfer from an idle DUT; acts as the slave and as the response consumer.
    task automatic xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                        input int waits, input logic [DW-1:0] rdata, input logic slverr,
                        input int rsp_hold, input int exp_acc, input logic exp_to,
                        input logic chain, input logic [AW-1:0] c_addr, input logic c_wr,
                        input logic [DW-1:0] c_wdata,
                        output logic [DW-1:0] got_rdata, output logic got_err);
        int  acc;
        bit  done;
        chk("idle_cmd_ready", 64'(cmd_ready_o), 64'd1);
        cmd_valid_i = 1'b1;
        cmd_addr_i  = addr;
        cmd_write_i = wr;
        cmd_wdata_i = wdata;
        exp_addr    = addr;
        exp_write   = wr;
        exp_wdata   = wdata;
        exp_rdata   = exp_to ? '0 : (wr ? '0 : rdata);
        exp_err     = exp_to ? 1'b1 : slverr;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        chk("setup_psel", 64'(psel_o), 64'd1);
        chk("setup_penable", 64'(penable_o), 64'd0);
        chk("setup_cmd_ready", 64'(cmd_ready_o), 64'd0);
        @(negedge clk_i);
        acc  = 0;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            if (psel_o && penable_o) begin
                acc++;
                pready_i  = (acc == waits + 1);
                prdata_i  = rdata;
                pslverr_i = slverr;
                @(negedge clk_i);
            end else begin
                done = 1'b1;
            end
        end
        pready_i  = 1'b0;
        pslverr_i = 1'b0;
        prdata_i  = 32'h5A5A_0F0F;
        if (!done) begin
            errors++;
            $display("FAIL access_bound: ACCESS still active after 200 cycles at %0t", $time);
        end
        chk("access_cycles", 64'(acc), 64'(exp_acc));
        chk("rsp_valid_rise", 64'(rsp_valid_o), 64'd1);
        chk("rsp_psel_low", 64'({psel_o, penable_o}), 64'd0);
        got_rdata = rsp_rdata_o;
        got_err   = rsp_err_o;
        if (chain) begin
            cmd_valid_i = 1'b1;
            cmd_addr_i  = c_addr;
            cmd_write_i = c_wr;
            cmd_wdata_i = c_wdata;
        end
        rsp_ready_i = 1'b0;
        for (int i = 0; i < rsp_hold; i++) begin
            chk("hold_rsp_valid", 64'(rsp_valid_o), 64'd1);
            chk("hold_rdata", 64'(rsp_rdata_o), 64'(got_rdata));
            chk("hold_err", 64'(rsp_err_o), 64'(got_err));
            chk("hold_cmd_ready", 64'(cmd_ready_o), 64'd0);
            chk("hold_paddr", 64'(paddr_o), 64'(addr));
            @(negedge clk_i);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        chk("after_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("after_cmd_ready", 64'(cmd_ready_o), 64'd1);
        chk("after_psel", 64'(psel_o), 64'd0);
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic          er;

        // Reset state
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
        chk("rst_ctl", 64'({psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_err_o}), 64'd0);
        chk("rst_paddr", 64'(paddr_o), 64'd0);
        chk("rst_data", 64'({pwdata_o, rsp_rdata_o}), 64'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("rel_cmd_ready_before_clk", 64'(cmd_ready_o), 64'd0);
        @(negedge clk_i);
        chk("rel_cmd_ready_after_clk", 64'(cmd_ready_o), 64'd1);
        mon_en = 1'b1;

        // Zero-wait write
        xfer(32'h1000_0004, 1'b1, 32'hDEAD_BEEF, 0, 32'h5555_AAAA, 1'b0, 0, 1, 1'b0,
             1'b0, '0, 1'b0, '0, rd, er);
        chk("wr0_rdata_lit", 64'(rd), 64'h0);
        chk("wr0_err_lit", 64'(er), 64'h0);

        // Read with three wait states
        xfer(32'h2000_0010, 1'b0, 32'h0, 3, 32'h1234_5678, 1'b0, 0, 4, 1'b0,
             1'b0, '0, 1'b0, '0, rd, er);
        chk("rd3_rdata_lit", 64'(rd), 64'h1234_5678);
        chk("rd3_err_lit", 64'(er), 64'h0);

        // Slave error on a read
        xfer(32'h2000_0020, 1'b0, 32'h0, 0, 32'hFFFF_FFFF, 1'b1, 0, 1, 1'b0,
             1'b0, '0, 1'b0, '0, rd, er);
        chk("slverr_rdata_lit", 64'(rd), 64'hFFFF_FFFF);
        chk("slverr_err_lit", 64'(er), 64'h1);

        // Response backpressure with the next command already waiting
        xfer(32'h3000_0000, 1'b1, 32'h0BAD_F00D, 1, 32'h0, 1'b0, 5, 2, 1'b0,
             1'b1, 32'h3000_0008, 1'b0, 32'h0, rd, er);
        chk("bp_err_lit", 64'(er), 64'h0);
        xfer(32'h3000_0008, 1'b0, 32'h0, 1, 32'hCAFE_0001, 1'b0, 0, 2, 1'b0,
             1'b0, '0, 1'b0, '0, rd, er);
        chk("b2b_rdata_lit", 64'(rd), 64'hCAFE_0001);

`ifdef APB_MASTER_TIMEOUT_EN
        // Slave never ready: abort after TO ACCESS cycles
        xfer(32'h4000_0000, 1'b0, 32'h0, 100, 32'h7777_7777, 1'b0, 0, 4, 1'b1,
             1'b0, '0, 1'b0, '0, rd, er);
        chk("to_rdata_lit", 64'(rd), 64'h0);
        chk("to_err_lit", 64'(er), 64'h1);
        // Ready in the last allowed cycle completes normally
        xfer(32'h4000_0004, 1'b0, 32'h0, 3, 32'hA5A5_0004, 1'b0, 0, 4, 1'b0,
             1'b0, '0, 1'b0, '0, rd, er);
        chk("to_edge_rdata_lit", 64'(rd), 64'hA5A5_0004);
        chk("to_edge_err_lit", 64'(er), 64'h0);
`else
        // Without the watchdog a long wait is simply tolerated
        xfer(32'h4000_0000, 1'b0, 32'h0, 10, 32'h7777_7777, 1'b0, 0, 11, 1'b0,
             1'b0, '0, 1'b0, '0, rd, er);
        chk("long_wait_rdata_lit", 64'(rd), 64'h7777_7777);
        chk("long_wait_err_lit", 64'(er), 64'h0);
`endif

        // Async reset during the second ACCESS cycle of a read
        cmd_valid_i = 1'b1;
        cmd_addr_i  = 32'h5000_00F0;
        cmd_write_i = 1'b0;
        cmd_wdata_i = 32'h1111_2222;
        exp_addr    = 32'h5000_00F0;
        exp_write   = 1'b0;
        exp_wdata   = 32'h1111_2222;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        chk("rstmid_access1", 64'({psel_o, penable_o}), 64'h3);
        @(negedge clk_i);
        chk("rstmid_access2", 64'({psel_o, penable_o}), 64'h3);
        #2;
        rst_i = 1'b1;
        #1;
        chk("rstmid_ctl", 64'({cmd_ready_o, psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_err_o}), 64'd0);
        chk("rstmid_paddr", 64'(paddr_o), 64'd0);
        chk("rstmid_data", 64'({pwdata_o, rsp_rdata_o}), 64'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("rstmid_no_rsp", 64'({rsp_valid_o, psel_o}), 64'd0);
        end
        xfer(32'h6000_0000, 1'b1, 32'h0123_4567, 0, 32'h0, 1'b0, 0, 1, 1'b0,
             1'b0, '0, 1'b0, '0, rd, er);
        chk("post_rst_err_lit", 64'(er), 64'h0);

        @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global guard against a stalled run
    initial begin
        #200000;
        $display("FAIL global_timeout: run exceeded time limit");
        $fatal(1, "global timeout");
    end

endmodule
